// File: rtl/de1_sram_pkg.sv
// de1_sram_pkg
// Shared types and constants for the DE1 SRAM arbiter:
//   - state_t : sequencer states (IDLE, ACC, REC)
//   - SRAM_ADDR_W / SRAM_DATA_W : geometry of the 256K x 16 SRAM
//   - cmd_t   : command latched from the winning port
package de1_sram_pkg;

    localparam int SRAM_ADDR_W = 18;
    localparam int SRAM_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        REC  = 2'd2
    } state_t;

    typedef struct packed {
        logic                   we;
        logic [SRAM_ADDR_W-1:0] addr;
        logic [SRAM_DATA_W-1:0] wdata;
        logic [1:0]             be;
    } cmd_t;

endpackage

// File: rtl/de1_sram_grant.sv
// de1_sram_grant
// Two-way grant logic for the SRAM arbiter. Produces a one-hot (or zero)
// grant from the two request lines.
//   Build macro SRAM_ARB_RR_EN:
//     defined   : round-robin; on a tie the port not granted last wins.
//                 The last-grant register resets to port 1, so port 0
//                 wins the first tie after reset.
//     undefined : fixed priority, port 0 always wins; no last-grant flop.
// Ports:
//   i_clk, i_rst_n : clock, async active-low reset (used only for round-robin)
//   i_req[1:0]     : request per port
//   i_take         : the current grant is being consumed this cycle
//   o_gnt[1:0]     : grant per port
module de1_sram_grant (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [1:0] i_req,
    input  logic       i_take,
    output logic [1:0] o_gnt
);

`ifdef SRAM_ARB_RR_EN
    logic r_last;

    always_comb begin
        o_gnt = i_req;
        if (i_req == 2'b11) begin
            o_gnt = r_last ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last <= 1'b1;
        end else if (i_take) begin
            r_last <= o_gnt[1];
        end
    end
`else
    // Clock, reset and take only matter for the round-robin build.
    logic w_unused;
    assign w_unused = i_clk ^ i_rst_n ^ i_take;

    assign o_gnt = {i_req[1] & ~i_req[0], i_req[0]};
`endif

endmodule

// File: rtl/de1_sram_arbiter.sv
// de1_sram_arbiter
// Two-port arbiter and access sequencer for the DE1 256K x 16 async SRAM.
// One access at a time; every SRAM pin is driven from a register.
// Arbitration mode is selected by the SRAM_ARB_RR_EN macro inside
// de1_sram_grant (fixed priority to port 0 when undefined).
// Ports:
//   CLOCK_50, RESET_N        : clock, async active-low reset
//   pN_req/we/addr/wdata/be  : port N command, held until pN_ack
//   pN_ack                   : one-cycle pulse, command accepted
//   pN_rdata, pN_rvalid      : read data and its one-cycle valid pulse
//   SRAM_DQ                  : bidirectional data bus
//   SRAM_ADDR, SRAM_*_N      : address and active-low controls
// ADDR_W/DATA_W must match the package geometry (the command latch uses it).
//
// state | meaning
// IDLE  | no access; pick a winner and latch its command
// ACC   | strobe (OE_N or WE_N) low for ACC_CYCLES cycles
// REC   | strobes high, CE/ADDR/DQ held one cycle; read data valid
module de1_sram_arbiter
    import de1_sram_pkg::*;
#(
    parameter int ADDR_W     = SRAM_ADDR_W,
    parameter int DATA_W     = SRAM_DATA_W,
    parameter int ACC_CYCLES = 1
) (
    input  logic              CLOCK_50,
    input  logic              RESET_N,

    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    input  logic [1:0]        p0_be,
    output logic              p0_ack,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_rvalid,

    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    input  logic [1:0]        p1_be,
    output logic              p1_ack,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_rvalid,

    inout  wire  [DATA_W-1:0] SRAM_DQ,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    output logic              SRAM_UB_N,
    output logic              SRAM_LB_N,
    output logic              SRAM_WE_N,
    output logic              SRAM_CE_N,
    output logic              SRAM_OE_N
);

    localparam logic [3:0] CNT_LOAD = 4'(ACC_CYCLES - 1);

    state_t            r_state, w_state_nxt;
    logic [3:0]        r_cnt, w_cnt_nxt;
    cmd_t              r_cmd, w_cmd_nxt;
    cmd_t              w_cmd0, w_cmd1, w_sel;
    logic              r_gidx, w_gidx_nxt;
    logic              r_ce_n, w_ce_n_nxt;
    logic              r_oe_n, w_oe_n_nxt;
    logic              r_we_n, w_we_n_nxt;
    logic              r_ub_n, w_ub_n_nxt;
    logic              r_lb_n, w_lb_n_nxt;
    logic              r_dq_oe, w_dq_oe_nxt;
    logic [1:0]        r_ack, w_ack_nxt;
    logic [1:0]        r_rvalid, w_rvalid_nxt;
    logic [DATA_W-1:0] r_rdata0, w_rdata0_nxt;
    logic [DATA_W-1:0] r_rdata1, w_rdata1_nxt;
    logic [1:0]        w_gnt;
    logic              w_take;

    de1_sram_grant u_grant (
        .i_clk   (CLOCK_50),
        .i_rst_n (RESET_N),
        .i_req   ({p1_req, p0_req}),
        .i_take  (w_take),
        .o_gnt   (w_gnt)
    );

    always_comb begin
        w_cmd0 = '{we: p0_we, addr: p0_addr, wdata: p0_wdata, be: p0_be};
        w_cmd1 = '{we: p1_we, addr: p1_addr, wdata: p1_wdata, be: p1_be};
        w_sel  = w_gnt[1] ? w_cmd1 : w_cmd0;
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_cmd_nxt    = r_cmd;
        w_gidx_nxt   = r_gidx;
        w_ce_n_nxt   = r_ce_n;
        w_oe_n_nxt   = r_oe_n;
        w_we_n_nxt   = r_we_n;
        w_ub_n_nxt   = r_ub_n;
        w_lb_n_nxt   = r_lb_n;
        w_dq_oe_nxt  = r_dq_oe;
        w_ack_nxt    = 2'b00;
        w_rvalid_nxt = 2'b00;
        w_rdata0_nxt = r_rdata0;
        w_rdata1_nxt = r_rdata1;
        w_take       = 1'b0;
        case (r_state)
            IDLE: begin
                if (|w_gnt) begin
                    w_take      = 1'b1;
                    w_gidx_nxt  = w_gnt[1];
                    w_cmd_nxt   = w_sel;
                    w_state_nxt = ACC;
                    w_cnt_nxt   = CNT_LOAD;
                    w_ce_n_nxt  = 1'b0;
                    w_oe_n_nxt  = w_sel.we;
                    w_we_n_nxt  = ~w_sel.we;
                    // Reads enable both bytes; writes honour the byte enables.
                    w_ub_n_nxt  = w_sel.we & ~w_sel.be[1];
                    w_lb_n_nxt  = w_sel.we & ~w_sel.be[0];
                    w_dq_oe_nxt = w_sel.we;
                    w_ack_nxt   = w_gnt;
                end
            end
            ACC: begin
                w_ub_n_nxt = r_cmd.we & ~r_cmd.be[1];
                w_lb_n_nxt = r_cmd.we & ~r_cmd.be[0];
                if (r_cnt == 4'd0) begin
                    w_state_nxt = REC;
                    w_oe_n_nxt  = 1'b1;
                    w_we_n_nxt  = 1'b1;
                    if (!r_cmd.we) begin
                        // Bus is still driven by the SRAM on this edge.
                        if (r_gidx) begin
                            w_rdata1_nxt = SRAM_DQ;
                            w_rvalid_nxt = 2'b10;
                        end else begin
                            w_rdata0_nxt = SRAM_DQ;
                            w_rvalid_nxt = 2'b01;
                        end
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            REC: begin
                w_state_nxt = IDLE;
                w_ce_n_nxt  = 1'b1;
                w_ub_n_nxt  = 1'b1;
                w_lb_n_nxt  = 1'b1;
                w_dq_oe_nxt = 1'b0;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_cnt    <= 4'd0;
            r_cmd    <= '0;
            r_gidx   <= 1'b0;
            r_ce_n   <= 1'b1;
            r_oe_n   <= 1'b1;
            r_we_n   <= 1'b1;
            r_ub_n   <= 1'b1;
            r_lb_n   <= 1'b1;
            r_dq_oe  <= 1'b0;
            r_ack    <= 2'b00;
            r_rvalid <= 2'b00;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            r_cnt    <= w_cnt_nxt;
            r_cmd    <= w_cmd_nxt;
            r_gidx   <= w_gidx_nxt;
            r_ce_n   <= w_ce_n_nxt;
            r_oe_n   <= w_oe_n_nxt;
            r_we_n   <= w_we_n_nxt;
            r_ub_n   <= w_ub_n_nxt;
            r_lb_n   <= w_lb_n_nxt;
            r_dq_oe  <= w_dq_oe_nxt;
            r_ack    <= w_ack_nxt;
            r_rvalid <= w_rvalid_nxt;
            r_rdata0 <= w_rdata0_nxt;
            r_rdata1 <= w_rdata1_nxt;
        end
    end

    assign SRAM_DQ   = r_dq_oe ? r_cmd.wdata : {DATA_W{1'bz}};
    assign SRAM_ADDR = r_cmd.addr;
    assign SRAM_CE_N = r_ce_n;
    assign SRAM_OE_N = r_oe_n;
    assign SRAM_WE_N = r_we_n;
    assign SRAM_UB_N = r_ub_n;
    assign SRAM_LB_N = r_lb_n;

    assign p0_ack    = r_ack[0];
    assign p1_ack    = r_ack[1];
    assign p0_rvalid = r_rvalid[0];
    assign p1_rvalid = r_rvalid[1];
    assign p0_rdata  = r_rdata0;
    assign p1_rdata  = r_rdata1;

endmodule

// File: tb/tb_de1_sram_arbiter.sv
module tb_de1_sram_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    int n_cmp = 0;
    int n_bad = 0;

    // DUT A: ACC_CYCLES = 1, backed by a memory model
    logic        a_p0_req, a_p0_we, a_p0_ack, a_p0_rvalid;
    logic [17:0] a_p0_addr;
    logic [15:0] a_p0_wdata, a_p0_rdata;
    logic [1:0]  a_p0_be;
    logic        a_p1_req, a_p1_we, a_p1_ack, a_p1_rvalid;
    logic [17:0] a_p1_addr;
    logic [15:0] a_p1_wdata, a_p1_rdata;
    logic [1:0]  a_p1_be;
    wire  [15:0] a_dq;
    logic [17:0] a_addr;
    logic        a_ub_n, a_lb_n, a_we_n, a_ce_n, a_oe_n;

    // DUT B: ACC_CYCLES = 3, backed by an address-pattern ROM model
    logic        b_p0_req, b_p0_we, b_p0_ack, b_p0_rvalid;
    logic [17:0] b_p0_addr;
    logic [15:0] b_p0_wdata, b_p0_rdata;
    logic [1:0]  b_p0_be;
    logic        b_p1_ack, b_p1_rvalid;
    logic [15:0] b_p1_rdata;
    wire  [15:0] b_dq;
    logic [17:0] b_addr;
    logic        b_ub_n, b_lb_n, b_we_n, b_ce_n, b_oe_n;

    de1_sram_arbiter #(.ACC_CYCLES(1)) dut_a (
        .CLOCK_50(clk), .RESET_N(rst_n),
        .p0_req(a_p0_req), .p0_we(a_p0_we), .p0_addr(a_p0_addr), .p0_wdata(a_p0_wdata),
        .p0_be(a_p0_be), .p0_ack(a_p0_ack), .p0_rdata(a_p0_rdata), .p0_rvalid(a_p0_rvalid),
        .p1_req(a_p1_req), .p1_we(a_p1_we), .p1_addr(a_p1_addr), .p1_wdata(a_p1_wdata),
        .p1_be(a_p1_be), .p1_ack(a_p1_ack), .p1_rdata(a_p1_rdata), .p1_rvalid(a_p1_rvalid),
        .SRAM_DQ(a_dq), .SRAM_ADDR(a_addr), .SRAM_UB_N(a_ub_n), .SRAM_LB_N(a_lb_n),
        .SRAM_WE_N(a_we_n), .SRAM_CE_N(a_ce_n), .SRAM_OE_N(a_oe_n)
    );

    de1_sram_arbiter #(.ACC_CYCLES(3)) dut_b (
        .CLOCK_50(clk), .RESET_N(rst_n),
        .p0_req(b_p0_req), .p0_we(b_p0_we), .p0_addr(b_p0_addr), .p0_wdata(b_p0_wdata),
        .p0_be(b_p0_be), .p0_ack(b_p0_ack), .p0_rdata(b_p0_rdata), .p0_rvalid(b_p0_rvalid),
        .p1_req(1'b0), .p1_we(1'b0), .p1_addr(18'h0), .p1_wdata(16'h0),
        .p1_be(2'b00), .p1_ack(b_p1_ack), .p1_rdata(b_p1_rdata), .p1_rvalid(b_p1_rvalid),
        .SRAM_DQ(b_dq), .SRAM_ADDR(b_addr), .SRAM_UB_N(b_ub_n), .SRAM_LB_N(b_lb_n),
        .SRAM_WE_N(b_we_n), .SRAM_CE_N(b_ce_n), .SRAM_OE_N(b_oe_n)
    );

    // Asynchronous SRAM device models
    logic [15:0] mem_a [0:262143];
    assign a_dq = (!a_ce_n && !a_oe_n && a_we_n) ? mem_a[a_addr] : 16'hzzzz;
    always @(negedge clk) begin
        if (!a_ce_n && !a_we_n) begin
            if (!a_ub_n) mem_a[a_addr][15:8] <= a_dq[15:8];
            if (!a_lb_n) mem_a[a_addr][7:0]  <= a_dq[7:0];
        end
    end
    assign b_dq = (!b_ce_n && !b_oe_n && b_we_n) ? (b_addr[15:0] ^ 16'h5A5A) : 16'hzzzz;

    // Reference model: expected memory contents
    logic [15:0] ref_mem [int];

    function automatic void model_write(input logic [17:0] addr, input logic [15:0] wd,
                                        input logic [1:0] be);
        logic [15:0] v;
        v = ref_mem.exists(int'(addr)) ? ref_mem[int'(addr)] : 16'h0000;
        if (be[1]) v[15:8] = wd[15:8];
        if (be[0]) v[7:0]  = wd[7:0];
        ref_mem[int'(addr)] = v;
    endfunction

    // Drives one access on DUT A and reports what was seen; pins = {CE,OE,WE,UB,LB}
    task automatic access(input int port, input bit we, input logic [17:0] addr,
                          input logic [15:0] wd, input logic [1:0] be,
                          output int ack_lat, output int rv_lat, output logic [15:0] rd,
                          output logic [4:0] pins, output logic [17:0] paddr,
                          output logic [15:0] pdq, output logic ack_again);
        ack_lat = -1; rv_lat = -1; rd = 16'h0; pins = 5'h1F;
        paddr = 18'h0; pdq = 16'h0; ack_again = 1'b0;
        @(negedge clk);
        if (port == 0) begin
            a_p0_we = we; a_p0_addr = addr; a_p0_wdata = wd; a_p0_be = be; a_p0_req = 1'b1;
        end else begin
            a_p1_we = we; a_p1_addr = addr; a_p1_wdata = wd; a_p1_be = be; a_p1_req = 1'b1;
        end
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if ((port == 0) ? a_p0_ack : a_p1_ack) begin
                ack_lat = i;
                pins = {a_ce_n, a_oe_n, a_we_n, a_ub_n, a_lb_n};
                paddr = a_addr;
                pdq = a_dq;
                break;
            end
        end
        a_p0_req = 1'b0;
        a_p1_req = 1'b0;
        if (ack_lat > 0) begin
            for (int i = 1; i <= 16; i++) begin
                @(negedge clk);
                if (i == 1) ack_again = (port == 0) ? a_p0_ack : a_p1_ack;
                if (!we && ((port == 0) ? a_p0_rvalid : a_p1_rvalid)) begin
                    rv_lat = i;
                    rd = (port == 0) ? a_p0_rdata : a_p1_rdata;
                    break;
                end
                if (we && i >= 2) break;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        a_p0_req = 0; a_p0_we = 0; a_p0_addr = 0; a_p0_wdata = 0; a_p0_be = 0;
        a_p1_req = 0; a_p1_we = 0; a_p1_addr = 0; a_p1_wdata = 0; a_p1_be = 0;
        b_p0_req = 0; b_p0_we = 0; b_p0_addr = 0; b_p0_wdata = 0; b_p0_be = 0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({a_ce_n, a_oe_n, a_we_n, a_ub_n, a_lb_n} !== 5'h1F) begin
            n_bad++; $display("FAIL reset_strobes_a: got %b want 11111", {a_ce_n, a_oe_n, a_we_n, a_ub_n, a_lb_n});
        end
        n_cmp++;
        if ({b_ce_n, b_oe_n, b_we_n, b_ub_n, b_lb_n} !== 5'h1F) begin
            n_bad++; $display("FAIL reset_strobes_b: got %b want 11111", {b_ce_n, b_oe_n, b_we_n, b_ub_n, b_lb_n});
        end
        n_cmp++;
        if (a_addr !== 18'h0) begin
            n_bad++; $display("FAIL reset_addr: got %h want 00000", a_addr);
        end
        n_cmp++;
        if ({a_p0_ack, a_p1_ack, a_p0_rvalid, a_p1_rvalid} !== 4'b0000) begin
            n_bad++; $display("FAIL reset_ack_rvalid: got %b want 0000", {a_p0_ack, a_p1_ack, a_p0_rvalid, a_p1_rvalid});
        end
        n_cmp++;
        if ({a_p0_rdata, a_p1_rdata} !== 32'h0) begin
            n_bad++; $display("FAIL reset_rdata: got %h want 00000000", {a_p0_rdata, a_p1_rdata});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write_read_p1;
        int al, rl; logic [15:0] rd, pdq; logic [4:0] pins; logic [17:0] pa; logic aa;
        access(1, 1'b1, 18'h00010, 16'hA5C3, 2'b11, al, rl, rd, pins, pa, pdq, aa);
        model_write(18'h00010, 16'hA5C3, 2'b11);
        n_cmp++;
        if (al !== 1) begin n_bad++; $display("FAIL p1_wr_ack_latency: got %0d want 1", al); end
        n_cmp++;
        if (aa !== 1'b0) begin n_bad++; $display("FAIL p1_wr_ack_pulse: got %b want 0", aa); end
        n_cmp++;
        if (pins !== 5'b01000) begin n_bad++; $display("FAIL p1_wr_pins: got %b want 01000", pins); end
        n_cmp++;
        if (pa !== 18'h00010 || pdq !== 16'hA5C3) begin
            n_bad++; $display("FAIL p1_wr_bus: got addr %h dq %h want 00010 a5c3", pa, pdq);
        end
        access(1, 1'b0, 18'h00010, 16'h0000, 2'b00, al, rl, rd, pins, pa, pdq, aa);
        n_cmp++;
        if (al !== 1 || rl !== 1) begin
            n_bad++; $display("FAIL p1_rd_latency: got ack %0d rvalid %0d want 1 1", al, rl);
        end
        n_cmp++;
        if (rd !== 16'hA5C3) begin n_bad++; $display("FAIL p1_rd_data: got %h want a5c3", rd); end
        n_cmp++;
        if (pins !== 5'b00100) begin n_bad++; $display("FAIL p1_rd_pins: got %b want 00100", pins); end
    endtask

    task automatic test_top_addr_p0;
        int al, rl; logic [15:0] rd, pdq; logic [4:0] pins; logic [17:0] pa; logic aa;
        access(0, 1'b1, 18'h3FFFF, 16'hFFFF, 2'b11, al, rl, rd, pins, pa, pdq, aa);
        model_write(18'h3FFFF, 16'hFFFF, 2'b11);
        n_cmp++;
        if (pa !== 18'h3FFFF) begin n_bad++; $display("FAIL p0_top_addr: got %h want 3ffff", pa); end
        access(0, 1'b1, 18'h3FFFF, 16'h1200, 2'b10, al, rl, rd, pins, pa, pdq, aa);
        model_write(18'h3FFFF, 16'h1200, 2'b10);
        n_cmp++;
        if (pins !== 5'b01001) begin n_bad++; $display("FAIL p0_be10_pins: got %b want 01001", pins); end
        access(0, 1'b0, 18'h3FFFF, 16'h0000, 2'b00, al, rl, rd, pins, pa, pdq, aa);
        n_cmp++;
        if (rd !== 16'h12FF || rl !== 1) begin
            n_bad++; $display("FAIL p0_be10_readback: got %h lat %0d want 12ff lat 1", rd, rl);
        end
    endtask

    task automatic test_be_none;
        int al, rl; logic [15:0] rd, pdq; logic [4:0] pins; logic [17:0] pa; logic aa;
        access(1, 1'b1, 18'h00010, 16'h0000, 2'b00, al, rl, rd, pins, pa, pdq, aa);
        model_write(18'h00010, 16'h0000, 2'b00);
        n_cmp++;
        if (al !== 1 || pins !== 5'b01011) begin
            n_bad++; $display("FAIL be00_cycle: got ack %0d pins %b want 1 01011", al, pins);
        end
        access(0, 1'b0, 18'h00010, 16'h0000, 2'b00, al, rl, rd, pins, pa, pdq, aa);
        n_cmp++;
        if (rd !== 16'hA5C3) begin n_bad++; $display("FAIL be00_unchanged: got %h want a5c3", rd); end
    endtask

    task automatic test_reset_mid_write;
        @(negedge clk);
        a_p1_we = 1'b1; a_p1_addr = 18'h00020; a_p1_wdata = 16'h5AA5; a_p1_be = 2'b11; a_p1_req = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (a_we_n !== 1'b0) begin n_bad++; $display("FAIL midrst_we_low: got %b want 0", a_we_n); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({a_ce_n, a_oe_n, a_we_n, a_ub_n, a_lb_n} !== 5'h1F) begin
            n_bad++; $display("FAIL midrst_strobes: got %b want 11111", {a_ce_n, a_oe_n, a_we_n, a_ub_n, a_lb_n});
        end
        n_cmp++;
        if (a_dq !== 16'hzzzz && a_dq !== 16'h0000) begin
            n_bad++; $display("FAIL midrst_dq_release: got %h want hi-z", a_dq);
        end
        n_cmp++;
        if (a_p1_ack !== 1'b0 || a_addr !== 18'h0) begin
            n_bad++; $display("FAIL midrst_ack_addr: got %b %h want 0 00000", a_p1_ack, a_addr);
        end
        a_p1_req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            n_cmp++;
            if ({a_p0_ack, a_p1_ack, a_p0_rvalid, a_p1_rvalid, a_we_n} !== 5'b00001) begin
                n_bad++;
                $display("FAIL midrst_quiet_%0d: got %b want 00001", n, {a_p0_ack, a_p1_ack, a_p0_rvalid, a_p1_rvalid, a_we_n});
            end
        end
    endtask

    task automatic test_arbitration;
        int last, win;
        logic e0, e1;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        a_p0_we = 1'b0; a_p0_addr = 18'h00010; a_p0_req = 1'b1;
        a_p1_we = 1'b0; a_p1_addr = 18'h3FFFF; a_p1_req = 1'b1;
        last = 1;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            e0 = 1'b0; e1 = 1'b0;
            // With both ports always requesting, an access takes 3 cycles.
            if (n % 3 == 1) begin
`ifdef SRAM_ARB_RR_EN
                win = (last == 1) ? 0 : 1;
`else
                win = 0;
`endif
                last = win;
                if (win == 0) e0 = 1'b1; else e1 = 1'b1;
            end
            n_cmp++;
            if (a_p0_ack !== e0 || a_p1_ack !== e1) begin
                n_bad++; $display("FAIL arb_cycle_%0d: got p0 %b p1 %b want p0 %b p1 %b", n, a_p0_ack, a_p1_ack, e0, e1);
            end
        end
        a_p0_req = 1'b0;
        a_p1_req = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_long_strobe;
        int ack_n, rv_n, oe_first, oe_cnt;
        logic [17:0] addr;
        logic [15:0] rd;
        for (int t = 0; t < 3; t++) begin
            addr = 18'($urandom_range(262143, 0));
            @(negedge clk);
            b_p0_we = 1'b0; b_p0_addr = addr; b_p0_req = 1'b1;
            ack_n = -1; rv_n = -1; oe_first = -1; oe_cnt = 0; rd = 16'h0;
            for (int n = 1; n <= 10; n++) begin
                @(negedge clk);
                if (b_p0_ack) begin
                    if (ack_n < 0) ack_n = n;
                    b_p0_req = 1'b0;
                end
                if (!b_oe_n) begin
                    oe_cnt++;
                    if (oe_first < 0) oe_first = n;
                end
                if (b_p0_rvalid && rv_n < 0) begin
                    rv_n = n;
                    rd = b_p0_rdata;
                end
            end
            b_p0_req = 1'b0;
            n_cmp++;
            if (ack_n !== 1 || oe_first !== 1 || oe_cnt !== 3) begin
                n_bad++; $display("FAIL acc3_oe_window: got ack %0d oe_first %0d oe_len %0d want 1 1 3", ack_n, oe_first, oe_cnt);
            end
            // ACC covers sample+1..sample+3, rvalid at sample+4.
            n_cmp++;
            if (rv_n !== 4) begin n_bad++; $display("FAIL acc3_rvalid_cycle: got %0d want 4", rv_n); end
            n_cmp++;
            if (rd !== (addr[15:0] ^ 16'h5A5A)) begin
                n_bad++; $display("FAIL acc3_rdata: got %h want %h", rd, addr[15:0] ^ 16'h5A5A);
            end
        end
    endtask

    task automatic test_random;
        logic [17:0] pool [8];
        int al, rl, port, idx;
        bit we;
        logic [15:0] rd, pdq, wd;
        logic [4:0] pins, epins;
        logic [17:0] pa, addr;
        logic [1:0] be;
        logic aa;
        pool = '{18'h00000, 18'h3FFFF, 18'h00001, 18'h15555, 18'h2AAAA, 18'h00100, 18'h1FFFF, 18'h30000};
        for (int i = 0; i < 8; i++) begin
            wd = 16'($urandom);
            access(i % 2, 1'b1, pool[i], wd, 2'b11, al, rl, rd, pins, pa, pdq, aa);
            model_write(pool[i], wd, 2'b11);
        end
        for (int i = 0; i < 40; i++) begin
            idx  = $urandom_range(7, 0);
            port = $urandom_range(1, 0);
            we   = 1'($urandom_range(1, 0));
            be   = 2'($urandom_range(3, 0));
            wd   = 16'($urandom);
            addr = pool[idx];
            access(port, we, addr, wd, be, al, rl, rd, pins, pa, pdq, aa);
            n_cmp++;
            if (al !== 1 || pa !== addr) begin
                n_bad++; $display("FAIL rnd_%0d_ack_addr: got lat %0d addr %h want 1 %h", i, al, pa, addr);
            end
            if (we) begin
                epins = {1'b0, 1'b1, 1'b0, ~be[1], ~be[0]};
                n_cmp++;
                if (pins !== epins || pdq !== wd) begin
                    n_bad++; $display("FAIL rnd_%0d_write: got pins %b dq %h want %b %h", i, pins, pdq, epins, wd);
                end
                model_write(addr, wd, be);
            end else begin
                n_cmp++;
                if (rl !== 1 || rd !== ref_mem[int'(addr)] || pins !== 5'b00100) begin
                    n_bad++;
                    $display("FAIL rnd_%0d_read: got lat %0d data %h pins %b want 1 %h 00100", i, rl, rd, pins, ref_mem[int'(addr)]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read_p1();
        test_top_addr_p0();
        test_be_none();
        test_reset_mid_write();
        test_arbitration();
        test_long_strobe();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
